// File: rtl/nibble_serial_subtract_ctrl.sv
// nibble_serial_subtract_ctrl
// Computes a - b (16 bits) four bits per cycle through a single 4-bit
// subtract slice (a_nib + ~b_nib + c_in), with a valid/ready start request
// and a valid/ready result handshake. Flags are produced as the last nibble
// is written.

module nibble_serial_subtract_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        done_valid,
   input  logic        done_ready,
   output logic [15:0] result,
   output logic        carry_out,
   output logic        overflow,
   output logic        zero,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  nib_idx;
   logic        carry_reg;
   logic [15:0] a_reg;
   logic [15:0] b_reg;

   logic [3:0]  a_nib;
   logic [3:0]  b_nib;
   logic        c_in;
   logic [4:0]  slice_sum;
   logic        last_nib;
   logic        final_overflow;
   logic        final_zero;

   // Single 4-bit subtract slice fed by the nibble selected by nib_idx
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      a_nib          = 4'(a_reg >> {nib_idx, 2'b00});
      b_nib          = 4'(b_reg >> {nib_idx, 2'b00});
      c_in           = (nib_idx == 2'd0) ? 1'b1 : carry_reg;
      slice_sum      = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, c_in};
      last_nib       = (nib_idx == 2'd3);
      // Flags on the last nibble must see the bits being written this cycle,
      // not the stale upper nibble still sitting in result.
      final_overflow = (a_reg[15] != b_reg[15]) && (slice_sum[3] != a_reg[15]);
      final_zero     = ({slice_sum[3:0], result[11:0]} == 16'h0000);
   end

   // Control FSM, operand capture, per-nibble result write and final flags
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state       <= IDLE;
         nib_idx     <= 2'd0;
         carry_reg   <= 1'b0;
         a_reg       <= 16'h0000;
         b_reg       <= 16'h0000;
         result      <= 16'h0000;
         carry_out   <= 1'b0;
         overflow    <= 1'b0;
         zero        <= 1'b0;
         start_ready <= 1'b1;
         done_valid  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_reg       <= a;
                  b_reg       <= b;
                  nib_idx     <= 2'd0;
                  state       <= RUN;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            RUN: begin
               result[{nib_idx, 2'b00} +: 4] <= slice_sum[3:0];
               carry_reg <= slice_sum[4];
               nib_idx   <= nib_idx + 2'd1;
               if (last_nib) begin
                  carry_out  <= slice_sum[4];
                  overflow   <= final_overflow;
                  zero       <= final_zero;
                  state      <= DONE;
                  busy       <= 1'b0;
                  done_valid <= 1'b1;
               end
            end
            DONE: begin
               // start_valid is deliberately ignored here; the earliest new
               // acceptance is the edge after returning to IDLE.
               if (done_ready) begin
                  state       <= IDLE;
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               start_ready <= 1'b1;
               done_valid  <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
